// File: rtl/pipelined_add_unit_pkg.sv
// Shared definitions for the ADD functional unit and its reservation stations.
package pipelined_add_unit_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_e;

    function automatic logic is_sub(logic op);
        return op == OP_SUB;
    endfunction

endpackage

// File: rtl/pipelined_add_unit_cla_slice.sv
// Combinational carry-lookahead adder slice used by each pipeline stage.
module cla_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         term;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of generate terms, not a ripple chain.
    always_comb begin
        c    = '0;
        term = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i+1] = term | (pp & cin);
        end
    end

    assign sum  = p ^ c[W-1:0];
    assign cout = c[W];

endmodule

// File: rtl/pipelined_add_unit.sv
// Pipelined ADD/SUB unit: one lookahead slice per stage, carry registered
// between stages, valid/ready handshake on both sides.
module pipelined_add_unit
    import pipelined_add_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SW = WIDTH / STAGES;

    logic                          advance;

    logic [STAGES:1]               r_v;
    logic [STAGES:1]               r_c;
    logic [STAGES:1][WIDTH-1:0]    r_a;
    logic [STAGES:1][WIDTH-1:0]    r_b;
    logic [STAGES:1][WIDTH-1:0]    r_s;
    logic [STAGES:1][TAG_W-1:0]    r_t;

    logic [STAGES-1:0]             st_v;
    logic [STAGES-1:0]             st_c;
    logic [STAGES-1:0][WIDTH-1:0]  st_a;
    logic [STAGES-1:0][WIDTH-1:0]  st_b;
    logic [STAGES-1:0][WIDTH-1:0]  st_s;
    logic [STAGES-1:0][TAG_W-1:0]  st_t;

    logic [STAGES-1:0][SW-1:0]     sl_s;
    logic [STAGES-1:0]             sl_c;
    logic [STAGES-1:0][WIDTH-1:0]  nx_s;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance && !flush;

    // Stage 0 reads the ports; SUB becomes A + ~B + 1 right here.
    always_comb begin
        st_v[0] = in_valid && in_ready;
        st_a[0] = in_a;
        st_b[0] = is_sub(in_op) ? ~in_b : in_b;
        st_c[0] = is_sub(in_op) ? 1'b1 : in_cin;
        st_s[0] = '0;
        st_t[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k] = r_v[k];
            st_a[k] = r_a[k];
            st_b[k] = r_b[k];
            st_c[k] = r_c[k];
            st_s[k] = r_s[k];
            st_t[k] = r_t[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(
            .W(SW)
        ) u_slice (
            .a   (st_a[k][k*SW +: SW]),
            .b   (st_b[k][k*SW +: SW]),
            .cin (st_c[k]),
            .sum (sl_s[k]),
            .cout(sl_c[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nx_s[k]              = st_s[k];
            nx_s[k][k*SW +: SW]  = sl_s[k];
        end
    end

    // Packed ranges line up so stage k feeds register k+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            r_a <= '0;
            r_b <= '0;
            r_s <= '0;
            r_t <= '0;
        end else begin
            if (advance) begin
                r_c <= sl_c;
                r_a <= st_a;
                r_b <= st_b;
                r_s <= nx_s;
                r_t <= st_t;
            end
            if (flush) begin
                r_v <= '0;
            end else if (advance) begin
                r_v <= st_v;
            end
        end
    end

    assign out_valid = r_v[STAGES];
    assign out_sum   = r_s[STAGES];
    assign out_cout  = r_c[STAGES];
    assign out_tag   = r_t[STAGES];
    assign out_ovf   = (r_a[STAGES][WIDTH-1] == r_b[STAGES][WIDTH-1])
                    && (r_s[STAGES][WIDTH-1] != r_a[STAGES][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_add_unit.sv
// Scoreboard bench for pipelined_add_unit: a 32-bit/2-stage and a
// 16-bit/4-stage instance driven with directed vectors.
module tb_pipelined_add_unit;
    import pipelined_add_unit_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [3:0]  tag;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        rst32, iv32, ir32, cin32, op32, fl32, ov32, or32, oc32, oo32;
    logic [31:0] a32, b32, s32;
    logic [3:0]  t32, ot32;

    logic        rst16, iv16, ir16, cin16, op16, fl16, ov16, or16, oc16, oo16;
    logic [15:0] a16, b16, s16;
    logic [3:0]  t16, ot16;

    exp_t q32[$];
    exp_t q16[$];
    vec_t v32[8];
    vec_t v16[6];

    pipelined_add_unit #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u32 (
        .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32),
        .in_a(a32), .in_b(b32), .in_cin(cin32), .in_op(op32),
        .in_tag(t32), .flush(fl32), .out_valid(ov32), .out_ready(or32),
        .out_sum(s32), .out_cout(oc32), .out_ovf(oo32), .out_tag(ot32)
    );

    pipelined_add_unit #(.WIDTH(16), .STAGES(4), .TAG_W(4)) u16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16),
        .in_a(a16), .in_b(b16), .in_cin(cin16), .in_op(op16),
        .in_tag(t16), .flush(fl16), .out_valid(ov16), .out_ready(or16),
        .out_sum(s16), .out_cout(oc16), .out_ovf(oo16), .out_tag(ot16)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    always begin : mon32
        exp_t got;
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst32 && ov32 && or32) begin
            got = {s32, oc32, oo32, ot32};
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon32: unexpected result %0h", got);
            end else begin
                e = q32.pop_front();
                chk("mon32", 64'(got), 64'(e));
            end
        end
    end

    always begin : mon16
        exp_t got;
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst16 && ov16 && or16) begin
            got = {16'h0, s16, oc16, oo16, ot16};
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon16: unexpected result %0h", got);
            end else begin
                e = q16.pop_front();
                chk("mon16", 64'(got), 64'(e));
            end
        end
    end

    task automatic issue32(input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin,
                           input logic [3:0] tag, input logic [31:0] es,
                           input logic ec, input logic eo);
        bit acc;
        int n;
        op32 = op; a32 = a; b32 = b; cin32 = cin; t32 = tag; iv32 = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            #1 acc = ir32;
            @(posedge clk);
            if (acc) q32.push_back({es, ec, eo, tag});
            @(negedge clk);
            n++;
        end
        iv32 = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue32: tag %0d never accepted", tag);
        end
    endtask

    task automatic issue16(input logic op, input logic [15:0] a,
                           input logic [15:0] b, input logic cin,
                           input logic [3:0] tag, input logic [15:0] es,
                           input logic ec, input logic eo);
        bit acc;
        int n;
        op16 = op; a16 = a; b16 = b; cin16 = cin; t16 = tag; iv16 = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            #1 acc = ir16;
            @(posedge clk);
            if (acc) q16.push_back({16'h0, es, ec, eo, tag});
            @(negedge clk);
            n++;
        end
        iv16 = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue16: tag %0d never accepted", tag);
        end
    endtask

    task automatic drain32();
        int n = 0;
        while (q32.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain32_left", 64'(q32.size()), 64'd0);
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain16_left", 64'(q16.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        v32[0] = '{OP_ADD, 32'd1147483647, 32'd1147483648, 1'b0, 4'd1,
                   32'd2294967295, 1'b0, 1'b1};
        v32[1] = '{OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 4'd2, 32'h0, 1'b1, 1'b0};
        v32[2] = '{OP_SUB, 32'd5, 32'd7, 1'b0, 4'd4, 32'hFFFFFFFE, 1'b0, 1'b0};
        v32[3] = '{OP_SUB, 32'd7, 32'd5, 1'b0, 4'd5, 32'd2, 1'b1, 1'b0};
        v32[4] = '{OP_ADD, 32'd10, 32'd20, 1'b1, 4'd6, 32'd31, 1'b0, 1'b0};
        v32[5] = '{OP_SUB, 32'd7, 32'd5, 1'b1, 4'd7, 32'd2, 1'b1, 1'b0};
        v32[6] = '{OP_SUB, 32'h80000000, 32'h1, 1'b0, 4'd8,
                   32'h7FFFFFFF, 1'b1, 1'b1};
        v32[7] = '{OP_ADD, 32'h0000FFFF, 32'h1, 1'b0, 4'd9,
                   32'h00010000, 1'b0, 1'b0};

        v16[0] = '{OP_ADD, 32'hFFFF, 32'h1, 1'b0, 4'd1, 32'h0, 1'b1, 1'b0};
        v16[1] = '{OP_ADD, 32'h4000, 32'h4000, 1'b0, 4'd2, 32'h8000, 1'b0, 1'b1};
        v16[2] = '{OP_SUB, 32'd5, 32'd7, 1'b0, 4'd3, 32'hFFFE, 1'b0, 1'b0};
        v16[3] = '{OP_SUB, 32'd7, 32'd5, 1'b0, 4'd4, 32'd2, 1'b1, 1'b0};
        v16[4] = '{OP_ADD, 32'h00FF, 32'h1, 1'b0, 4'd5, 32'h0100, 1'b0, 1'b0};
        v16[5] = '{OP_SUB, 32'h8000, 32'h1, 1'b0, 4'd6, 32'h7FFF, 1'b1, 1'b1};

        rst32 = 1'b1; iv32 = 1'b0; cin32 = 1'b0; op32 = 1'b0; fl32 = 1'b0;
        or32 = 1'b1; a32 = '0; b32 = '0; t32 = '0;
        rst16 = 1'b1; iv16 = 1'b0; cin16 = 1'b0; op16 = 1'b0; fl16 = 1'b0;
        or16 = 1'b1; a16 = '0; b16 = '0; t16 = '0;

        repeat (2) @(negedge clk);
        rst32 = 1'b0;
        rst16 = 1'b0;
        #1;
        chk("rst32_in_ready", 64'(ir32), 64'd1);
        chk("rst32_out_valid", 64'(ov32), 64'd0);
        chk("rst32_outs", 64'({s32, oc32, oo32, ot32}), 64'd0);
        chk("rst16_in_ready", 64'(ir16), 64'd1);
        chk("rst16_out_valid", 64'(ov16), 64'd0);
        chk("rst16_outs", 64'({s16, oc16, oo16, ot16}), 64'd0);
        @(negedge clk);

        // 32-bit: latency of exactly two cycles
        issue32(OP_ADD, 32'd2, 32'd5, 1'b0, 4'd3, 32'd7, 1'b0, 1'b0);
        #1 chk("lat32_c1", 64'(ov32), 64'd0);
        @(negedge clk);
        #1 chk("lat32_c2", 64'(ov32), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            issue32(v32[i].op, v32[i].a, v32[i].b, v32[i].cin, v32[i].tag,
                    v32[i].s, v32[i].c, v32[i].o);
        drain32();

        // 32-bit: back-to-back stream with a three-cycle stall
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue32(OP_ADD, 32'h0000FFF0 + 32'(i), 32'h10, 1'b0,
                            4'(10 + i), 32'h00010000 + 32'(i), 1'b0, 1'b0);
            end
            begin
                logic [31:0] keep;
                repeat (2) @(negedge clk);
                or32 = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    #1;
                    if (j == 0) keep = s32;
                    chk("stall_in_ready", 64'(ir32), 64'd0);
                    chk("stall_out_valid", 64'(ov32), 64'd1);
                    chk("stall_hold_sum", 64'(s32), 64'(keep));
                    @(negedge clk);
                end
                or32 = 1'b1;
            end
        join
        drain32();

        // 32-bit: flush with two ops in flight and a competing input
        or32 = 1'b0;
        issue32(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd1, 32'd2, 1'b0, 1'b0);
        issue32(OP_ADD, 32'd2, 32'd2, 1'b0, 4'd2, 32'd4, 1'b0, 1'b0);
        fl32 = 1'b1;
        iv32 = 1'b1; op32 = OP_ADD; a32 = 32'd9; b32 = 32'd9; t32 = 4'd5;
        #1;
        chk("flush_pre_valid", 64'(ov32), 64'd1);
        chk("flush_in_ready", 64'(ir32), 64'd0);
        @(posedge clk);
        q32.delete();
        @(negedge clk);
        fl32 = 1'b0;
        iv32 = 1'b0;
        or32 = 1'b1;
        for (int j = 0; j < 2; j++) begin
            #1 chk("flush_out_valid", 64'(ov32), 64'd0);
            @(negedge clk);
        end
        issue32(OP_ADD, 32'd3, 32'd4, 1'b0, 4'd12, 32'd7, 1'b0, 1'b0);
        drain32();

        // 16-bit / 4-stage: latency, vectors, then reset mid-stream
        issue16(OP_ADD, 16'd2, 16'd5, 1'b0, 4'd3, 16'd7, 1'b0, 1'b0);
        for (int j = 1; j < 4; j++) begin
            #1 chk("lat16_early", 64'(ov16), 64'd0);
            @(negedge clk);
        end
        #1 chk("lat16_c4", 64'(ov16), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            issue16(v16[i].op, v16[i].a[15:0], v16[i].b[15:0], v16[i].cin,
                    v16[i].tag, v16[i].s[15:0], v16[i].c, v16[i].o);
        drain16();

        for (int i = 0; i < 5; i++)
            issue16(OP_ADD, 16'h0100 + 16'(i), 16'h0001, 1'b0, 4'(i + 1),
                    16'h0101 + 16'(i), 1'b0, 1'b0);
        #1 chk("rst16_pre_valid", 64'(ov16), 64'd1);
        #2 rst16 = 1'b1;
        q16.delete();
        #1;
        chk("rst16_async_valid", 64'(ov16), 64'd0);
        chk("rst16_async_outs", 64'({s16, oc16, oo16, ot16}), 64'd0);
        @(negedge clk);
        rst16 = 1'b0;
        #1 chk("rst16_release_ready", 64'(ir16), 64'd1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            #1 chk("rst16_no_stale", 64'(ov16), 64'd0);
        end
        @(negedge clk);
        issue16(OP_SUB, 16'd7, 16'd5, 1'b0, 4'd9, 16'd2, 1'b1, 1'b0);
        drain16();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_add_unit.md
PIPELINED_ADD_UNIT -- requirements
Module: pipelined_add_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter STAGES, default 2, pipeline depth; WIDTH SHALL be divisible by STAGES.
REQ-003 Parameter TAG_W, default 4, width of the reservation-station tag carried alongside each operation.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operation presented this cycle.
REQ-007 in_ready  output  1  unit accepts an operation this cycle.
REQ-008 in_a, in_b  input  WIDTH  operands, unsigned/two's-complement agnostic.
REQ-009 in_cin  input  1  carry-in for ADD (ignored for SUB).
REQ-010 in_op  input  1  0 = ADD, 1 = SUB (A - B).
REQ-011 in_tag  input  TAG_W  tag of issuing reservation station.
REQ-012 flush  input  1  discard all in-flight operations.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer (CDB arbiter) takes result this cycle.
REQ-015 out_sum  output  WIDTH  result; out_cout output 1 carry-out; out_ovf output 1 signed overflow; out_tag output TAG_W tag of result.

Function
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 ADD SHALL compute {cout,sum} = A + B + in_cin, modulo 2^WIDTH for sum.
REQ-018 SUB SHALL compute A + ~B + 1; out_cout = 1 means no borrow (A >= B unsigned).
REQ-019 out_ovf SHALL be 1 when operand sign bits (A, effective B) agree and differ from sum sign bit.
REQ-020 Stage k (0..STAGES-1) SHALL add slice k of width WIDTH/STAGES using carry-lookahead, registering the carry into stage k+1; upper operand slices are delayed to stay aligned.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid without backpressure; throughput one operation per cycle.
REQ-022 Pipeline SHALL advance when !(out_valid && !out_ready); otherwise all stages hold, including tags and per-stage valid bits.
REQ-023 in_ready SHALL equal !(out_valid && !out_ready) && !flush.
REQ-024 Outputs SHALL stay stable while out_valid && !out_ready.
REQ-025 flush SHALL clear every stage valid bit on the next edge, dominating a simultaneous input or output transfer; out_valid is 0 the cycle after flush.
REQ-026 Bubbles SHALL propagate with valid = 0; data registers of invalid stages are don't-care.

Reset
REQ-027 On rst asserted, all stage valid bits and out_valid SHALL clear immediately, independent of clk.
REQ-028 out_sum, out_cout, out_ovf, out_tag SHALL reset to 0.
REQ-029 An operation in flight when rst asserts SHALL be lost; no output for it after rst release.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Op encoding constants (OP_ADD, OP_SUB) SHALL live in a shared package/header used by the ADD reservation stations.
REQ-032 A sub-module cla_slice (parametrised width, generate/propagate lookahead, carry in/out) SHALL implement each stage's combinational adder.
REQ-033 Stage registers SHALL be generated from STAGES; no hard-coded depth.

Verification
REQ-034 WIDTH=32, STAGES=2: ADD 2+5, cin=0, tag=3 -> after 2 cycles sum=7, cout=0, ovf=0, tag=3.
REQ-035 ADD 1147483647+1147483648 -> sum=2294967295, cout=0, ovf=1; ADD 0xFFFFFFFF+1 -> sum=0, cout=1, ovf=0.
REQ-036 SUB 5-7 -> sum=0xFFFFFFFE, cout=0, ovf=0; SUB 7-5 -> sum=2, cout=1.
REQ-037 Stream 6 back-to-back ADDs, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, all 6 results emerge in order with correct tags, none duplicated or lost.
REQ-038 Issue 2 ops then assert flush with in_valid=1 -> out_valid stays 0 for following STAGES cycles; next op after flush returns correct result.
REQ-039 Repeat REQ-034..036 with WIDTH=16, STAGES=4 and assert rst mid-stream -> outputs 0 immediately, no stale result after release.
